// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extension with a 2-entry skid buffer
module imm_ext_pipe #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam int EW = XLEN + TAG_W + 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_next;
  logic [31:7] w;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm;
  logic [EW-1:0] entry, main, skid;
  logic accept, drain;
  assign w = instr;
  // extend the incoming word; formats signed on instr[31] share a 32-bit form that is then widened
  always_comb begin
    imm32 = '0;
    imm = '0;
    case (imm_src)
      3'b000: imm32 = {{20{w[31]}}, w[31:20]};
      3'b001: imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      3'b010: imm32 = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      3'b011: imm32 = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      3'b100: imm32 = {w[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    case (imm_src)
      3'b101: imm = XLEN'(w[19:15]);
      3'b110: imm = XLEN == 64 ? XLEN'(w[25:20]) : XLEN'(w[24:20]);
      3'b111: imm = '0;
      default: imm = XLEN'($signed(imm32));
    endcase
  end
  assign entry = {imm, in_tag, imm_src == 3'b111};
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  // state register
  always_ff @(posedge clk) state <= reset ? EMPTY : state_next;
  // buffer occupancy transitions
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: state_next = accept ? ONE : EMPTY;
      ONE: state_next = accept && !drain ? TWO : !accept && drain ? EMPTY : ONE;
      TWO: state_next = drain ? ONE : TWO;
      default: state_next = EMPTY;
    endcase
  end
  // handshake flags depend only on registered state
  always_comb begin
    in_ready = state != TWO;
    out_valid = state != EMPTY;
  end
  // main takes the input unless the skid holds an older entry; skid only fills when main is stalled
  always_ff @(posedge clk)
    if (reset) begin
      main <= '0;
      skid <= '0;
    end else begin
      if (state == TWO ? drain : accept && (state == EMPTY || drain)) main <= state == TWO ? skid : entry;
      if (state == ONE && accept && !drain) skid <= entry;
    end
  assign {imm_ext, out_tag, out_illegal} = main;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: randomized and directed checks of imm_ext_pipe against a queue model
module tb_imm_ext_pipe;
  logic clk = 0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [24:0] instr;
  logic [2:0] imm_src;
  logic [4:0] in_tag, out_tag;
  logic [31:0] imm_ext;
  logic v64, ir64, ov64, or64, oill64;
  logic [24:0] instr64;
  logic [2:0] src64;
  logic [4:0] tag64, otag64;
  logic [63:0] imm64;
  int total = 0;
  int bad = 0;

  typedef struct {logic [31:0] imm; logic [4:0] tag; logic ill;} ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .imm_ext(imm_ext), .out_tag(out_tag), .out_illegal(out_illegal));

  imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(ir64), .instr(instr64),
    .imm_src(src64), .in_tag(tag64), .out_valid(ov64), .out_ready(or64),
    .imm_ext(imm64), .out_tag(otag64), .out_illegal(oill64));

  logic [39:0] obs;
  assign obs = {out_valid, in_ready, imm_ext, out_tag, out_illegal};

  function automatic longint sext(longint x, int n);
    longint m;
    m = x & ((64'sd1 << n) - 1);
    return m[n-1] ? m - (64'sd1 << n) : m;
  endfunction

  // immediate value from the instruction encoding rules, as an integer
  function automatic logic [63:0] ref_imm(logic [31:0] w, logic [2:0] s, bit x64);
    longint v;
    case (s)
      3'd0: v = sext(longint'(w >> 20), 12);
      3'd1: v = sext(longint'(((w >> 25) << 5) | ((w >> 7) & 31)), 12);
      3'd2: v = sext(longint'(((w >> 31) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1)), 13);
      3'd3: v = sext(longint'(((w >> 31) << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1)), 21);
      3'd4: v = sext(longint'(w & 32'hFFFFF000), 32);
      3'd5: v = longint'((w >> 15) & 31);
      3'd6: v = longint'((w >> 20) & (x64 ? 63 : 31));
      default: v = 0;
    endcase
    return x64 ? 64'(v) : {32'b0, 32'(v)};
  endfunction

  function automatic logic [39:0] exp_v();
    return q.size() == 0 ? {2'b01, 38'b0} : {1'b1, q.size() < 2, q[0].imm, q[0].tag, q[0].ill};
  endfunction

  function automatic logic [39:0] msk();
    return q.size() == 0 ? {2'b11, 38'b0} : '1;
  endfunction

  // drive one cycle of stimulus at a negedge and advance the model across the next posedge
  task automatic drive(input bit v, input logic [31:0] w, input logic [2:0] s, input logic [4:0] t, input bit ordy);
    ent_t e;
    logic [63:0] r;
    bit acc;
    acc = v && q.size() < 2;
    in_valid = v;
    instr = w[31:7];
    imm_src = v ? s : 3'bx;
    in_tag = t;
    out_ready = ordy;
    r = ref_imm(w, s, 0);
    e.imm = r[31:0];
    e.tag = t;
    e.ill = s == 3'b111;
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1;
    in_valid = 0; instr = '0; imm_src = '0; in_tag = '0; out_ready = 1;
    v64 = 0; instr64 = '0; src64 = '0; tag64 = '0; or64 = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    total++;
    if (obs !== 40'h40_0000_0000) begin
      bad++;
      $display("FAIL reset32 got=%h want=%h", obs, 40'h40_0000_0000);
    end
    total++;
    if ({ov64, ir64, imm64, otag64, oill64} !== {1'b0, 1'b1, 70'b0}) begin
      bad++;
      $display("FAIL reset64 got=%b %b %h %h %b", ov64, ir64, imm64, otag64, oill64);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ws[4] = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h123450B7};
    logic [2:0] ss[4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [31:0] es[4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000};
    for (int i = 0; i < 4; i++) begin
      drive(1, ws[i], ss[i], 5'(i + 1), 1);
      total++;
      if ({out_valid, in_ready, imm_ext, out_tag, out_illegal} !== {2'b11, es[i], 5'(i + 1), 1'b0}) begin
        bad++;
        $display("FAIL directed%0d got=%h want=%h tag=%0d", i, imm_ext, es[i], out_tag);
      end
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL directed_drain out_valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_illegal();
    drive(1, $urandom, 3'd7, 5'd7, 1);
    total++;
    if ({out_valid, imm_ext, out_tag, out_illegal} !== {1'b1, 32'h0, 5'd7, 1'b1}) begin
      bad++;
      $display("FAIL illegal got v=%b imm=%h tag=%0d ill=%b want 1/0/7/1", out_valid, imm_ext, out_tag, out_illegal);
    end
    drive(1, 32'hFFF00093, 3'd0, 5'd8, 1);
    total++;
    if ({out_valid, imm_ext, out_tag, out_illegal} !== {1'b1, 32'hFFFFFFFF, 5'd8, 1'b0}) begin
      bad++;
      $display("FAIL illegal_next got imm=%h tag=%0d ill=%b want ffffffff/8/0", imm_ext, out_tag, out_illegal);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    w = 32'h00500013;
    drive(1, w, 3'd0, 5'd1, 0);
    drive(1, w, 3'd0, 5'd2, 0);
    total++;
    if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 5'd1}) begin
      bad++;
      $display("FAIL bp_full in_ready=%b out_valid=%b tag=%0d want 0/1/1", in_ready, out_valid, out_tag);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, w, 3'd0, 5'd3, 0);
      total++;
      if ((obs & msk()) !== exp_v() || out_tag !== 5'd1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h want=%h", i, obs, exp_v());
      end
    end
    for (int i = 2; i <= 3; i++) begin
      drive(1, w, 3'd0, 5'd3, 1);
      total++;
      if (out_tag !== 5'(i) || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_order got tag=%0d v=%b want tag=%0d v=1", out_tag, out_valid, i);
      end
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if ((obs & msk()) !== exp_v() || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty got=%h want=%h", obs, exp_v());
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'hFFF00093, 3'd0, 5'd4, 0);
    drive(1, 32'hFFF00093, 3'd0, 5'd5, 0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_two in_ready=%b want 0", in_ready);
    end
    in_valid = 1; instr = 25'h1ABCDEF; imm_src = 3'd0; in_tag = 5'd9; out_ready = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    q.delete();
    total++;
    if (obs !== 40'h40_0000_0000) begin
      bad++;
      $display("FAIL rmid_reset got=%h want=%h", obs, 40'h40_0000_0000);
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_noaccept out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 10; i++) begin
      drive(1, $urandom, 3'($urandom_range(0, 6)), 5'(i), 1);
      total++;
      if ((obs & msk()) !== exp_v() || {out_valid, in_ready, out_tag} !== {2'b11, 5'(i)}) begin
        bad++;
        $display("FAIL stream%0d got=%h want=%h", i, obs, exp_v());
      end
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom), $urandom_range(0, 2) != 0);
      total++;
      if ((obs & msk()) !== exp_v()) begin
        bad++;
        $display("FAIL random%0d got=%h want=%h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] ws[3] = '{32'h800000B7, 32'h41F0D093, 32'h3400F073};
    logic [2:0] ss[3] = '{3'd4, 3'd6, 3'd5};
    logic [63:0] es[3] = '{64'hFFFFFFFF80000000, 64'h1F, 64'h1};
    logic [31:0] w;
    logic [2:0] s;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      w = i < 3 ? ws[i] : $urandom;
      s = i < 3 ? ss[i] : 3'($urandom_range(0, 7));
      e = i < 3 ? es[i] : ref_imm(w, s, 1);
      v64 = 1; instr64 = w[31:7]; src64 = s; tag64 = 5'(i); or64 = 1;
      @(negedge clk);
      total++;
      if ({ov64, ir64, imm64, otag64, oill64} !== {2'b11, e, 5'(i), s == 3'd7}) begin
        bad++;
        $display("FAIL x64_%0d got imm=%h tag=%0d ill=%b want imm=%h tag=%0d", i, imm64, otag64, oill64, e, i);
      end
    end
    v64 = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_stream();
    test_random();
    test_xlen64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate-extension stage for the decode pipeline.
- Accepts an instruction word (bits 31:7), a format select and a sideband tag through a valid/ready handshake.
- Produces the sign- or zero-extended immediate at XLEN width one cycle later, through a 2-entry skid buffer.
- Adds CSR-zimm and shift-amount formats and illegal-select flagging, and sustains full throughput under downstream back-pressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 5, width of the sideband tag (e.g. destination register index) carried alongside the immediate.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  reset; synchronous and active-high.
in_valid  input  1  upstream offers instr/imm_src/in_tag.
in_ready  output  1  stage can accept this cycle.
instr  input  25  instruction bits [31:7].
imm_src  input  3  format select.
in_tag  input  TAG_W  sideband tag, passed through unmodified.
out_valid  output  1  imm_ext/out_tag/out_illegal are valid.
out_ready  input  1  downstream accepts this cycle.
imm_ext  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag of the current output entry.
out_illegal  output  1  current entry had an illegal imm_src.

Behaviour:
Extension, computed combinationally at input and registered. "sx" = replicate instr[31] up to XLEN.
- 000 I: sx, instr[31:20].
- 001 S: sx, instr[31:25], instr[11:7].
- 010 B: sx, instr[7], instr[30:25], instr[11:8], 0.
- 011 J: sx, instr[19:12], instr[20], instr[30:21], 0.
- 100 U: instr[31:12], 12'b0. When XLEN=64, bits 63:32 = instr[31].
- 101 Z: zero-extend instr[19:15] (CSR zimm).
- 110 SHAMT: zero-extend instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
- 111: imm_ext=0, out_illegal=1. All legal codes give out_illegal=0.

Buffer: a main register (drives the outputs) plus one skid register. States:
- EMPTY: main invalid.
- ONE: main valid, skid empty.
- TWO: both valid.

Control:
- in_ready = (state != TWO), registered (not combinational from out_ready).
- out_valid = (state != EMPTY).
- A transfer occurs when valid && ready on the respective side.

Transitions:
- EMPTY: accept -> main, go to ONE.
- ONE, out-transfer and no accept: go to EMPTY.
- ONE, accept and out-transfer together: new entry -> main, stay in ONE.
- ONE, accept and no out-transfer: new entry -> skid, go to TWO.
- ONE, neither: hold.
- TWO, out-transfer: skid -> main, go to ONE. No accept is possible because in_ready=0.
- TWO, no out-transfer: hold all.

Timing and ordering:
- Latency: an entry accepted in cycle N is presented in cycle N+1 at the earliest.
- Throughput: 1 entry/cycle while out_ready=1.
- Strict FIFO order; no entry dropped or duplicated.
- Outputs stay stable while out_valid=1 and out_ready=0.

Reset:
- Synchronous. Next cycle: state EMPTY, out_valid=0, in_ready=1, imm_ext=0, out_tag=0, out_illegal=0.
- Reset takes priority over any simultaneous transfer.
- Reset mid-operation discards buffered entries, and the handshake is not completed for that cycle.

Boundaries:
- in_valid asserted while in_ready=0: ignored, with no state change. Upstream must hold its data.
- Data inputs are ignored when in_valid=0.
- An X on imm_src with in_valid=0 must not propagate into state.

Test Plan:
- XLEN=32, out_ready=1. Feed four entries back-to-back, one accepted per cycle, each output one cycle after acceptance:
  - 0xFFF00093, imm_src 000 -> imm_ext 0xFFFFFFFF.
  - 0xFE000EE3, 010 -> 0xFFFFFFFC.
  - 0x0080006F, 011 -> 0x00000008.
  - 0x123450B7, 100 -> 0x12345000.
- XLEN=64:
  - 0x800000B7, 100 -> 0xFFFFFFFF80000000.
  - 0x41F0D093, 110 -> 0x000000000000001F (SHAMT, srai, bits 25:20 = 011111).
  - 0x3400F073, 101 -> 0x0000000000000001 (Z).
- imm_src=111 with tag 7 -> imm_ext 0, out_illegal=1, out_tag=7. The next legal entry has out_illegal=0.
- Back-pressure: hold out_ready=0 and offer tags 1,2,3 on consecutive cycles.
  - Required: tags 1 and 2 accepted, in_ready=0 from the cycle after tag 2's acceptance, tag 3 held off, outputs stable.
  - Raise out_ready: outputs appear in order 1,2,3 with no gap after tag 3 is accepted.
- Reset mid-operation: assert reset in state TWO with out_ready=0.
  - Next cycle: out_valid=0, in_ready=1, imm_ext=0.
  - The entry offered in the reset cycle is not accepted.
- Simultaneous accept and drain in ONE for 10 cycles: out_valid stays 1, in_ready stays 1, tags appear in order with 1-cycle latency.
